// File: rtl/dlfloat_dot_seq.sv
// Dot-product sequencer for a single dl_mac (DLFloat16): streams (a,b) pairs and chains each result into d.
// Optional sticky saturation flag enabled by defining DLF_SEQ_OVF_FLAG_EN.
module dlfloat_dot_seq #(
   parameter int unsigned LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic [15:0]      init_acc,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   output logic [15:0]      mac_a,
   output logic [15:0]      mac_b,
   output logic [15:0]      mac_d,
   input  logic [19:0]      mac_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_result,
   output logic             busy,
   output logic             ovf_flag
);

   typedef enum logic [2:0] {S_IDLE, S_FEED, S_WAIT, S_DRAIN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic             first_q, first_d;
   logic [15:0]      acc_src_q, acc_src_d;
   logic [15:0]      mac_a_q, mac_a_d, mac_b_q, mac_b_d, mac_d_q, mac_d_d;
   logic [15:0]      out_result_q, out_result_d;
   logic             out_valid_q, out_valid_d;
   logic             unused_mac_c_hi;

   assign unused_mac_c_hi = ^mac_c[19:16];

   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      first_d      = first_q;
      acc_src_d    = acc_src_q;
      mac_a_d      = mac_a_q;
      mac_b_d      = mac_b_q;
      mac_d_d      = mac_d_q;
      out_result_d = out_result_q;
      out_valid_d  = out_valid_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  remaining_d = len;
                  acc_src_d   = init_acc;
                  first_d     = 1'b1;
                  state_d     = S_FEED;
               end else begin
                  out_result_d = init_acc;
                  out_valid_d  = 1'b1;
                  state_d      = S_DONE;
               end
            end
         end
         S_FEED: begin
            if (in_valid) begin
               mac_a_d = in_a;
               mac_b_d = in_b;
               // first pair seeds d with the command's accumulator, later pairs chain the MAC output
               mac_d_d = first_q ? acc_src_q : mac_c[15:0];
               first_d = 1'b0;
               if (remaining_q != '0) remaining_d = remaining_q - 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            state_d = (remaining_q != '0) ? S_FEED : S_DRAIN;
         end
         S_DRAIN: begin
            out_result_d = mac_c[15:0];
            out_valid_d  = 1'b1;
            state_d      = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         remaining_q  <= '0;
         first_q      <= 1'b0;
         acc_src_q    <= '0;
         mac_a_q      <= '0;
         mac_b_q      <= '0;
         mac_d_q      <= '0;
         out_result_q <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         first_q      <= first_d;
         acc_src_q    <= acc_src_d;
         mac_a_q      <= mac_a_d;
         mac_b_q      <= mac_b_d;
         mac_d_q      <= mac_d_d;
         out_result_q <= out_result_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign in_ready   = (state_q == S_FEED);
   assign busy       = (state_q != S_IDLE);
   assign mac_a      = mac_a_q;
   assign mac_b      = mac_b_q;
   assign mac_d      = mac_d_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;

`ifdef DLF_SEQ_OVF_FLAG_EN
   logic ovf_q, ovf_d;
   logic sat_c;

   assign sat_c = (mac_c[15:0] == 16'h7DFE) || (mac_c[15:0] == 16'hFDFE) || (mac_c[15:0] == 16'hFFFF);

   always_comb begin
      ovf_d = ovf_q;
      if (state_q == S_IDLE && start) ovf_d = 1'b0;
      else if (state_q == S_WAIT && sat_c) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign ovf_flag = ovf_q;
`else
   assign ovf_flag = 1'b0;
`endif

endmodule

// File: tb/tb_dlfloat_dot_seq.sv
// Directed bench for dlfloat_dot_seq; a behavioural DLFloat16 MAC stands in for dl_mac.
module tb_dlfloat_dot_seq;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic [15:0]      init_acc = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [15:0]      in_a = '0, in_b = '0;
   logic [15:0]      mac_a, mac_b, mac_d;
   logic [19:0]      mac_c = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [15:0]      out_result;
   logic             busy;
   logic             ovf_flag;

   int vecs = 0;
   int errs = 0;
   int lat;
   logic exp_ovf;

   logic [15:0] expd2 [3] = '{16'h0000, 16'h4000, 16'h4200};
   logic [15:0] expd4 [4] = '{16'h0000, 16'h3F00, 16'h4100, 16'h4240};

   always #5 clk = ~clk;

   dlfloat_dot_seq #(.LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .init_acc(init_acc),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_a(mac_a), .mac_b(mac_b), .mac_d(mac_d), .mac_c(mac_c),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .busy(busy), .ovf_flag(ovf_flag)
   );

   function automatic real dec(input logic [15:0] x);
      real v;
      int  e;
      if (x[14:9] == 6'd0) return 0.0;
      v = 1.0 + real'(x[8:0]) / 512.0;
      e = int'(x[14:9]) - 31;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return x[15] ? -v : v;
   endfunction

   function automatic logic [15:0] enc(input real r);
      real  m;
      int   e, mant;
      logic s;
      if (r == 0.0) return 16'h0000;
      s = (r < 0.0);
      m = s ? -r : r;
      e = 31;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0 && e > 0) begin m = m * 2.0; e--; end
      if (e <= 0) return 16'h0000;
      mant = $rtoi((m - 1.0) * 512.0);
      if (e > 62 || (e == 62 && mant > 510)) return s ? 16'hFDFE : 16'h7DFE;
      return {s, e[5:0], mant[8:0]};
   endfunction

   function automatic logic [15:0] mac_model(input logic [15:0] a, b, d);
      return enc(dec(a) * dec(b) + dec(d));
   endfunction

   // Upper nibble is junk that the sequencer must ignore
   always @(posedge clk) mac_c <= {4'hF, mac_model(mac_a, mac_b, mac_d)};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      check_eq(tag, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      check_eq(tag, {31'd0, out_valid}, 32'd1);
   endtask

   task automatic accept_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
`ifdef DLF_SEQ_OVF_FLAG_EN
      exp_ovf = 1'b1;
`else
      exp_ovf = 1'b0;
`endif
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check_eq("rst_busy", busy, 0);
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_mac_a", mac_a, 0);
      check_eq("rst_mac_d", mac_d, 0);
      check_eq("rst_result", out_result, 0);
      check_eq("rst_ovf", ovf_flag, 0);

      // 1: single pair 1.0*1.0
      start = 1'b1; len = 8'd1; init_acc = 16'h0000;
      tick();
      start = 1'b0; len = 8'hAA; init_acc = 16'h1234;
      check_eq("t1_busy", busy, 1);
      check_eq("t1_in_ready", in_ready, 1);
      in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h3E00;
      tick();
      in_valid = 1'b0; in_a = 16'hDEAD; in_b = 16'hBEEF;
      check_eq("t1_mac_a", mac_a, 16'h3E00);
      check_eq("t1_mac_b", mac_b, 16'h3E00);
      check_eq("t1_mac_d", mac_d, 16'h0000);
      check_eq("t1_rdy_wait", in_ready, 0);
      lat = 1;
      while (!out_valid && lat < 10) begin tick(); lat++; end
      check_eq("t1_latency", lat, 3);
      check_eq("t1_result", out_result, 16'h3E00);
      accept_result();
      check_eq("t1_ov_clr", out_valid, 0);
      check_eq("t1_idle", busy, 0);

      // 2: three pairs 1.0*2.0, continuous valid
      start = 1'b1; len = 8'd3; init_acc = 16'h0000;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h4000;
      for (int i = 0; i < 6; i++) begin
         check_eq("t2_rdy_pattern", in_ready, (i % 2 == 0));
         if (i % 2 == 1) check_eq("t2_mac_d", mac_d, expd2[i/2]);
         tick();
      end
      in_valid = 1'b0;
      wait_valid("t2_valid");
      check_eq("t2_result", out_result, 16'h4300);
      accept_result();

      // 3: zero length returns init_acc without issuing
      start = 1'b1; len = 8'd0; init_acc = 16'h4000;
      tick();
      start = 1'b0;
      check_eq("t3_valid", out_valid, 1);
      check_eq("t3_result", out_result, 16'h4000);
      check_eq("t3_mac_a", mac_a, 16'h3E00);
      check_eq("t3_mac_b", mac_b, 16'h4000);
      accept_result();
      check_eq("t3_ov_clr", out_valid, 0);

      // 4: gapped input, consumer stalls, start during DONE ignored
      start = 1'b1; len = 8'd4; init_acc = 16'h0000;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(0, 3)) tick();
         in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h3F00;
         wait_ready("t4_ready");
         tick();
         in_valid = 1'b0;
         check_eq("t4_mac_d", mac_d, expd4[k]);
      end
      wait_valid("t4_valid");
      for (int j = 0; j < 5; j++) begin
         if (j == 2) begin start = 1'b1; len = 8'd1; end
         check_eq("t4_hold_valid", out_valid, 1);
         check_eq("t4_hold_result", out_result, 16'h4300);
         check_eq("t4_no_ready", in_ready, 0);
         tick();
         start = 1'b0;
      end
      accept_result();
      check_eq("t4_ov_clr", out_valid, 0);
      tick();
      check_eq("t4_start_ignored", busy, 0);

      // 5: saturation
      start = 1'b1; len = 8'd2; init_acc = 16'h0000;
      tick();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_a = 16'h7C00; in_b = 16'h7C00;
         wait_ready("t5_ready");
         tick();
         in_valid = 1'b0;
      end
      check_eq("t5_mac_d", mac_d, 16'h7DFE);
      wait_valid("t5_valid");
      check_eq("t5_result", out_result, 16'h7DFE);
      check_eq("t5_ovf", ovf_flag, exp_ovf);
      accept_result();
      check_eq("t5_ovf_sticky", ovf_flag, exp_ovf);

      // 6: reset during WAIT, then a fresh command
      start = 1'b1; len = 8'd5; init_acc = 16'h0000;
      tick();
      start = 1'b0;
      check_eq("t6_ovf_cleared", ovf_flag, 0);
      in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h3E00;
      wait_ready("t6_ready");
      tick();
      in_valid = 1'b0;
      check_eq("t6_in_wait", mac_a, 16'h3E00);
      rst = 1'b1;
      #1;
      check_eq("t6_rst_busy", busy, 0);
      check_eq("t6_rst_mac_a", mac_a, 0);
      check_eq("t6_rst_mac_b", mac_b, 0);
      check_eq("t6_rst_mac_d", mac_d, 0);
      check_eq("t6_rst_in_ready", in_ready, 0);
      check_eq("t6_rst_out_valid", out_valid, 0);
      check_eq("t6_rst_result", out_result, 0);
      check_eq("t6_rst_ovf", ovf_flag, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check_eq("t6_post_rst_idle", busy, 0);
      start = 1'b1; len = 8'd1; init_acc = 16'h3E00;
      tick();
      start = 1'b0;
      in_valid = 1'b1; in_a = 16'h4000; in_b = 16'h4000;
      wait_ready("t6_ready2");
      tick();
      in_valid = 1'b0;
      check_eq("t6_mac_d", mac_d, 16'h3E00);
      wait_valid("t6_valid");
      check_eq("t6_result", out_result, 16'h4280);
      accept_result();
      check_eq("t6_done", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
